// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter:
//   size_e    : access size encodings (SZ_B, SZ_H, SZ_W, SZ_X = illegal)
//   req_id_e  : requester identifiers (REQ_CORE, REQ_DBG)
//   access_err: alignment / legal-size check for a request
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_e;

    // Returns 1 when the access is misaligned for its size or uses the
    // illegal size encoding.
    function automatic logic access_err(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
        case (size_e'(size))
            SZ_B:    access_err = 1'b0;
            SZ_H:    access_err = addr_lo[0];
            SZ_W:    access_err = |addr_lo;
            default: access_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a last-grant pointer.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset (pointer -> debug)
//   i_req  in   [0] = core request, [1] = debug request
//   o_gnt  out  one-hot combinational grant, forced to 0 during reset
// ---------------------------------------------------------------------------
module rr_arb2 import dmem_arb_pkg::*; (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    req_id_e r_last;

    // On contention the requester that did not win last time is chosen;
    // a lone requester always wins, so back-to-back grants are allowed.
    always_comb begin
        o_gnt = '0;
        if (!rst) begin
            if (i_req[0] && i_req[1]) begin
                if (r_last == REQ_DBG) o_gnt[0] = 1'b1;
                else                   o_gnt[1] = 1'b1;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    // Pointer moves only when something is actually granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= REQ_DBG;
        end else if (o_gnt[0]) begin
            r_last <= REQ_CORE;
        end else if (o_gnt[1]) begin
            r_last <= REQ_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates core and debug requests onto a single data-memory port.
// Pipeline: grant in cycle N (combinational), memory command in N+1
// (registered m_*), load data / error response in N+2.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   c_*/d_* req,we,size,addr,wdata  requester commands (held until grant)
//   c_gnt/d_gnt                  request accepted this cycle
//   c_rvalid/c_rdata/c_err (d_*) response to owning requester in N+2
//   c_stall                      core request pending without grant
//   m_en,m_we,m_size,m_addr,m_wdata  memory command (all 0 when idle)
//   m_rdata                      combinational read data for m_addr
// ---------------------------------------------------------------------------
module dmem_arbiter import dmem_arb_pkg::*; #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [1:0]        c_size,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              c_gnt,
    output logic              d_gnt,
    output logic              c_rvalid,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              c_err,
    output logic              d_err,
    output logic              c_stall,
    output logic              m_en,
    output logic              m_we,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    logic [1:0]        w_gnt;
    logic              w_any;
    req_id_e           w_owner;
    logic              w_we;
    logic [1:0]        w_size;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_err;
    logic              w_issue;
    logic              w_resp;

    // N+1 stage bookkeeping that travels alongside the m_* command.
    logic              r1_valid;
    req_id_e           r1_owner;
    logic              r1_load;
    logic              r1_err;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (reset),
        .i_req ({d_req, c_req}),
        .o_gnt (w_gnt)
    );

    assign c_gnt   = w_gnt[0];
    assign d_gnt   = w_gnt[1];
    assign c_stall = c_req & ~w_gnt[0];

    // Select the winning command.
    assign w_any   = |w_gnt;
    assign w_owner = w_gnt[1] ? REQ_DBG : REQ_CORE;
    assign w_we    = w_gnt[1] ? d_we    : c_we;
    assign w_size  = w_gnt[1] ? d_size  : c_size;
    assign w_addr  = w_gnt[1] ? d_addr  : c_addr;
    assign w_wdata = w_gnt[1] ? d_wdata : c_wdata;
    assign w_err   = access_err(w_size, w_addr[1:0]);

    // Erroneous requests are accepted but never reach the memory.
    assign w_issue = w_any & ~w_err;

    // Responses exist for loads and for every error (load or store).
    assign w_resp  = r1_valid & (r1_load | r1_err);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_valid <= 1'b0;
            r1_owner <= REQ_CORE;
            r1_load  <= 1'b0;
            r1_err   <= 1'b0;
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            m_size   <= '0;
            m_addr   <= '0;
            m_wdata  <= '0;
            c_rvalid <= 1'b0;
            c_rdata  <= '0;
            c_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
        end else begin
            // N -> N+1
            r1_valid <= w_any;
            r1_owner <= w_owner;
            r1_load  <= ~w_we;
            r1_err   <= w_err;
            m_en     <= w_issue;
            m_we     <= w_issue & w_we;
            m_size   <= w_issue ? w_size  : '0;
            m_addr   <= w_issue ? w_addr  : '0;
            m_wdata  <= w_issue ? w_wdata : '0;

            // N+1 -> N+2: m_rdata belongs to the command currently on m_*.
            c_rvalid <= w_resp & (r1_owner == REQ_CORE);
            c_err    <= w_resp & (r1_owner == REQ_CORE) & r1_err;
            c_rdata  <= (w_resp && r1_owner == REQ_CORE && !r1_err) ? m_rdata : '0;
            d_rvalid <= w_resp & (r1_owner == REQ_DBG);
            d_err    <= w_resp & (r1_owner == REQ_DBG) & r1_err;
            d_rdata  <= (w_resp && r1_owner == REQ_DBG && !r1_err) ? m_rdata : '0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter: directed vector table, directed
// multi-cycle sequences and a randomized run against a transaction-level
// reference model (grant order + shadow byte memory + response delay line).
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [1:0] c_size = '0, d_size = '0;
    logic [AW-1:0] c_addr = '0, d_addr = '0;
    logic [DW-1:0] c_wdata = '0, d_wdata = '0;
    logic c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err, c_stall, m_en, m_we;
    logic [DW-1:0] c_rdata, d_rdata, m_wdata, m_rdata;
    logic [1:0] m_size;
    logic [AW-1:0] m_addr;

    logic [7:0] mem [128];
    logic [7:0] shadow [128];
    logic [31:0] w_word;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .c_gnt(c_gnt), .d_gnt(d_gnt), .c_rvalid(c_rvalid), .d_rvalid(d_rvalid),
        .c_rdata(c_rdata), .d_rdata(d_rdata), .c_err(c_err), .d_err(d_err),
        .c_stall(c_stall), .m_en(m_en), .m_we(m_we), .m_size(m_size),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    // Initial memory image; word at 0x04 reads 0x0000000F.
    function automatic logic [7:0] pat(input int i);
        if (i == 4) return 8'h0F;
        if (i >= 5 && i <= 7) return 8'h00;
        return 8'(i * 7 + 3);
    endfunction

    // Bench memory: little-endian bytes, size-masked combinational read.
    assign w_word  = {mem[m_addr + 7'd3], mem[m_addr + 7'd2], mem[m_addr + 7'd1], mem[m_addr]};
    assign m_rdata = (m_size == 2'b00) ? {24'h0, w_word[7:0]} :
                     (m_size == 2'b01) ? {16'h0, w_word[15:0]} : w_word;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) mem[i] <= pat(i);
        end else if (m_en && m_we) begin
            mem[m_addr] <= m_wdata[7:0];
            if (m_size != 2'b00) mem[m_addr + 7'd1] <= m_wdata[15:8];
            if (m_size == 2'b10) begin
                mem[m_addr + 7'd2] <= m_wdata[23:16];
                mem[m_addr + 7'd3] <= m_wdata[31:24];
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        en;
        logic        we;
        logic [1:0]  size;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } mcmd_t;

    typedef struct packed {
        logic        valid;
        logic        owner;   // 0 core, 1 debug
        logic [31:0] data;
        logic        err;
    } resp_t;

    bit    last_dbg;
    mcmd_t pm;
    resp_t pr1, pr2;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit bad_access(input logic [1:0] sz, input logic [6:0] a);
        return (sz == 2'b11) || (sz == 2'b10 && (a % 4) != 0) || (sz == 2'b01 && (a % 2) != 0);
    endfunction

    function automatic logic [31:0] sh_rd(input int a, input int n);
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = shadow[(a + k) % 128];
        return r;
    endfunction

    task automatic model_reset();
        last_dbg = 1'b1;
        pm = '0;
        pr1 = '0;
        pr2 = '0;
        for (int i = 0; i < 128; i++) shadow[i] = pat(i);
    endtask

    task automatic do_reset();
        c_req = 1'b0;
        d_req = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One randomized cycle: compare DUT against model, then advance model.
    task automatic rand_cycle();
        bit gc, gd, err, we;
        logic [1:0] sz;
        logic [6:0] a;
        logic [31:0] wd;
        bit cv, dv;
        c_req = ($urandom_range(0, 2) != 0);
        d_req = ($urandom_range(0, 2) != 0);
        c_we = 1'($urandom);   d_we = 1'($urandom);
        c_size = 2'($urandom); d_size = 2'($urandom);
        c_addr = 7'($urandom); d_addr = 7'($urandom);
        if ($urandom_range(0, 3) != 0) c_addr = c_addr & ~7'(nbytes(c_size) - 1);
        if ($urandom_range(0, 3) != 0) d_addr = d_addr & ~7'(nbytes(d_size) - 1);
        c_wdata = $urandom; d_wdata = $urandom;
        @(negedge clk);
        gc = c_req && (!d_req || last_dbg);
        gd = d_req && (!c_req || !last_dbg);
        chk("rnd_gnt", 64'({c_gnt, d_gnt, c_stall}), 64'({gc, gd, c_req && !gc}));
        chk("rnd_mcmd", 64'({m_en, m_we, m_size, m_addr, m_wdata}), 64'(pm));
        cv = pr2.valid && !pr2.owner;
        dv = pr2.valid && pr2.owner;
        chk("rnd_c_resp", 64'({c_rvalid, c_err, c_rdata}),
            64'({cv, cv && pr2.err, cv ? pr2.data : 32'h0}));
        chk("rnd_d_resp", 64'({d_rvalid, d_err, d_rdata}),
            64'({dv, dv && pr2.err, dv ? pr2.data : 32'h0}));
        pr2 = pr1;
        pr1 = '0;
        pm = '0;
        if (gc || gd) begin
            we = gd ? d_we : c_we;
            sz = gd ? d_size : c_size;
            a  = gd ? d_addr : c_addr;
            wd = gd ? d_wdata : c_wdata;
            err = bad_access(sz, a);
            last_dbg = gd;
            if (err) begin
                pr1 = '{valid: 1'b1, owner: gd, data: 32'h0, err: 1'b1};
            end else begin
                pm = '{en: 1'b1, we: we, size: sz, addr: a, wdata: wd};
                if (!we) pr1 = '{valid: 1'b1, owner: gd, data: sh_rd(a, nbytes(sz)), err: 1'b0};
                else for (int k = 0; k < nbytes(sz); k++) shadow[(a + k) % 128] = wd[8*k +: 8];
            end
        end
        @(posedge clk); #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         creq;
        bit         dreq;
        bit         we;
        logic [1:0] size;
        logic [6:0] addr;
        bit         cg;
        bit         dg;
        bit         men;
        bit         err;
        bit         rv;
    } vec_t;

    vec_t tv [12];

    initial begin
        //            creq dreq we  size   addr   cg dg men err rv
        tv[0]  = '{1, 0, 0, 2'b10, 7'h04, 1, 0, 1, 0, 1};
        tv[1]  = '{1, 0, 0, 2'b10, 7'h06, 1, 0, 0, 1, 1};
        tv[2]  = '{1, 0, 0, 2'b01, 7'h01, 1, 0, 0, 1, 1};
        tv[3]  = '{1, 0, 0, 2'b01, 7'h02, 1, 0, 1, 0, 1};
        tv[4]  = '{1, 0, 0, 2'b11, 7'h00, 1, 0, 0, 1, 1};
        tv[5]  = '{1, 0, 1, 2'b10, 7'h08, 1, 0, 1, 0, 0};
        tv[6]  = '{0, 1, 0, 2'b00, 7'h03, 0, 1, 1, 0, 1};
        tv[7]  = '{1, 1, 0, 2'b10, 7'h08, 1, 0, 1, 0, 1};
        tv[8]  = '{1, 1, 0, 2'b10, 7'h08, 0, 1, 1, 0, 1};
        tv[9]  = '{0, 1, 0, 2'b01, 7'h05, 0, 1, 0, 1, 1};
        tv[10] = '{0, 1, 1, 2'b10, 7'h02, 0, 1, 0, 1, 1};
        tv[11] = '{0, 1, 1, 2'b00, 7'h01, 0, 1, 1, 0, 0};

        // Reset state
        #2;
        chk("rst_gnt_zero", 64'({c_gnt, d_gnt}), 64'(2'b00));
        chk("rst_outputs", 64'({m_en, m_we, c_rvalid, d_rvalid, c_err, d_err, c_rdata, d_rdata}), 64'h0);
        do_reset();

        for (int v = 0; v < 12; v++) begin
            c_req = tv[v].creq; d_req = tv[v].dreq;
            c_we = tv[v].we;    d_we = tv[v].we;
            c_size = tv[v].size; d_size = tv[v].size;
            c_addr = tv[v].addr; d_addr = tv[v].addr;
            c_wdata = $urandom;  d_wdata = $urandom;
            @(negedge clk);
            chk("tv_gnt", 64'({c_gnt, d_gnt}), 64'({tv[v].cg, tv[v].dg}));
            @(posedge clk); #1;
            c_req = 1'b0; d_req = 1'b0;
            @(negedge clk);
            chk("tv_men", 64'(m_en), 64'(tv[v].men));
            @(posedge clk); #1;
            @(negedge clk);
            chk("tv_c_resp", 64'({c_rvalid, c_err}), 64'({tv[v].cg && tv[v].rv, tv[v].cg && tv[v].err}));
            chk("tv_d_resp", 64'({d_rvalid, d_err}), 64'({tv[v].dg && tv[v].rv, tv[v].dg && tv[v].err}));
            if (tv[v].err) chk("tv_err_rdata", 64'(c_rdata | d_rdata), 64'h0);
            @(posedge clk); #1;
        end

        // Core load word 0x04 through the pipeline
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_size = 2'b10; c_addr = 7'h04;
        @(negedge clk);
        chk("lw04_gnt", 64'(c_gnt), 64'(1));
        @(posedge clk); #1;
        c_req = 1'b0;
        @(negedge clk);
        chk("lw04_m", 64'({m_en, m_we, m_addr}), 64'({1'b1, 1'b0, 7'h04}));
        @(posedge clk); #1;
        @(negedge clk);
        chk("lw04_resp", 64'({c_rvalid, c_err, c_rdata}), 64'({1'b1, 1'b0, 32'h0000000F}));
        @(posedge clk); #1;

        // Continuous contention alternates starting with the core
        do_reset();
        c_req = 1'b1; d_req = 1'b1; c_we = 1'b0; d_we = 1'b0;
        c_size = 2'b10; d_size = 2'b10; c_addr = '0; d_addr = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr_alt", 64'({c_gnt, d_gnt}), 64'((k % 2 == 0) ? 2'b10 : 2'b01));
            @(posedge clk); #1;
        end
        c_req = 1'b0; d_req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Debug byte store followed by core byte load of the same address
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_addr = 7'h04; d_wdata = 32'hAABBCC0F;
        @(negedge clk);
        chk("st_gnt", 64'(d_gnt), 64'(1));
        @(posedge clk); #1;
        d_req = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_size = 2'b00; c_addr = 7'h04;
        @(negedge clk);
        chk("st_m", 64'({m_en, m_we, m_addr, m_wdata[7:0]}), 64'({1'b1, 1'b1, 7'h04, 8'h0F}));
        chk("st_ld_gnt", 64'(c_gnt), 64'(1));
        @(posedge clk); #1;
        c_req = 1'b0;
        @(negedge clk);
        chk("st_no_rvalid", 64'(d_rvalid), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("st_ld_data", 64'({c_rvalid, c_rdata}), 64'({1'b1, 32'h0000000F}));
        @(posedge clk); #1;

        // Reset during N+1 of a core load
        do_reset();
        c_req = 1'b1; c_we = 1'b0; c_size = 2'b10; c_addr = 7'h04;
        @(negedge clk);
        chk("rs_gnt", 64'(c_gnt), 64'(1));
        @(posedge clk); #2;
        chk("rs_men_before", 64'(m_en), 64'(1));
        reset = 1'b1;
        #1;
        chk("rs_async_clear", 64'({m_en, c_rvalid, c_rdata}), 64'h0);
        chk("rs_gnt_low", 64'({c_gnt, d_gnt}), 64'(2'b00));
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; c_req = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rs_quiet", 64'({m_en, c_rvalid, d_rvalid}), 64'h0);
            @(posedge clk); #1;
        end
        c_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        chk("rs_first_contention", 64'({c_gnt, d_gnt}), 64'(2'b10));
        @(posedge clk); #1;
        c_req = 1'b0; d_req = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Core-only back-to-back word loads at 0x00, 0x04, 0x08
        do_reset();
        c_we = 1'b0; c_size = 2'b10;
        for (int k = 0; k < 5; k++) begin
            c_req = (k < 3);
            c_addr = 7'(4 * k);
            @(negedge clk);
            chk("b2b_stall", 64'(c_stall), 64'(0));
            if (k < 3) chk("b2b_gnt", 64'(c_gnt), 64'(1));
            if (k >= 2) chk("b2b_resp", 64'({c_rvalid, c_rdata}), 64'({1'b1, sh_rd(4 * (k - 2), 4)}));
            @(posedge clk); #1;
        end

        // Randomized run against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) rand_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, byte address width of the data memory (128 bytes).
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have these ports:
  clk  in  1  rising-edge clock
  reset  in  1  asynchronous active-high reset
  c_req/d_req  in  1  core/debug request (held until grant)
  c_we/d_we  in  1  1 = store, 0 = load
  c_size/d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
  c_addr/d_addr  in  ADDR_W  byte address
  c_wdata/d_wdata  in  DATA_W  store data
  c_gnt/d_gnt  out  1  request accepted this cycle
  c_rvalid/d_rvalid  out  1  load data or error response
  c_rdata/d_rdata  out  DATA_W  load data
  c_err/d_err  out  1  misaligned or illegal-size response
  c_stall  out  1  c_req & ~c_gnt
  m_en, m_we  out  1  memory access strobe, write enable
  m_size  out  2  access size
  m_addr  out  ADDR_W  memory address
  m_wdata  out  DATA_W  memory write data
  m_rdata  in  DATA_W  combinational read data for m_addr

Function
REQ-005 SHALL accept at most one request per cycle; gnt is combinational in the cycle of acceptance (cycle N).
REQ-006 SHALL arbitrate round-robin: with both requesting, grant the requester not granted most recently; with one requesting, grant it, back-to-back allowed.
REQ-007 SHALL update the last-grant pointer only on a grant.
REQ-008 SHALL register the accepted command onto m_* in cycle N+1, with m_en=1 for one cycle; m_* hold 0 when idle.
REQ-009 SHALL capture m_rdata at the end of N+1 and present rdata with rvalid=1 to the owning requester for one cycle in N+2, for loads only.
REQ-010 SHALL assert no rvalid for stores; store completes at the N+1 edge.
REQ-011 SHALL sustain one access per cycle (pipelined N+1/N+2 stages, owner tag carried per stage).
REQ-012 SHALL treat word with addr[1:0]!=0, half with addr[0]!=0, or size=11 as an error: grant normally, m_en=0 in N+1, err=1 in N+2 with rvalid=1 and rdata=0 (loads and stores alike).
REQ-013 SHALL hold rdata of an idle requester at 0.
REQ-014 SHALL NOT grant a requester whose req drops before grant; a dropped request is simply lost.
REQ-015 SHALL bound wait time: a continuously requesting requester is granted within 2 cycles.

Reset
REQ-016 SHALL, on reset assertion, clear immediately all registered outputs (m_*, rvalid, rdata, err) to 0 and set the last-grant pointer to debug, so the core wins the first contention.
REQ-017 SHALL discard in-flight N+1/N+2 transactions on reset: no m_en, no rvalid after reset assertion.
REQ-018 SHALL drive gnt=0 while reset is high.

Structure
REQ-019 SHALL place size encodings (SZ_B, SZ_H, SZ_W), requester IDs (REQ_CORE, REQ_DBG) and the alignment-check function in shared package dmem_arb_pkg.
REQ-020 SHALL implement arbitration in sub-module rr_arb2 (2 requests, last-grant pointer, one-hot grant).

Verification
REQ-021 Core load word addr 0x04, memory holds 0x0000000F -> c_gnt at N, m_en/m_addr=0x04 at N+1, c_rvalid=1 with c_rdata=0x0000000F at N+2.
REQ-022 Both requesting continuously for 6 cycles after reset -> grants C,D,C,D,C,D; no cycle with both gnt.
REQ-023 Debug store byte 0x0F at 0x04, then core load byte 0x04 next cycle -> m_we at N+1, core reads 0x0F at N+3.
REQ-024 Core load word addr 0x06 -> c_gnt, m_en=0 at N+1, c_rvalid=1, c_err=1, c_rdata=0 at N+2; size=11 gives same result.
REQ-025 Reset asserted in N+1 of a core load -> m_en, c_rvalid, c_rdata drop to 0 immediately; no response after release; first contention after reset grants core.
REQ-026 Core-only back-to-back loads at 0x00,0x04,0x08 -> three consecutive grants, rvalid on three consecutive cycles, c_stall=0 throughout.
